// File: rtl/keypad_digit_buffer_pkg.sv
// Shared definitions for the keypad input stage: FSM states, keypad idle/reset patterns
// and small helpers for decoding active-low row/column vectors.
package keypad_digit_buffer_pkg;

  localparam int         DIGIT_W   = 4;
  localparam logic [3:0] KB_IDLE   = 4'b1111;
  localparam logic [3:0] COL_RESET = 4'b1110;

  typedef enum logic [1:0] {
    ST_SCAN       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_ACCEPT     = 2'd2,
    ST_RELEASE_DB = 2'd3
  } kb_state_e;

  // Position of the lowest zero bit; 0 when no bit is low.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic one_low(input logic [3:0] v);
    return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
  endfunction

endpackage

// File: rtl/keypad_digit_buffer_scan_tick.sv
// Free-running slot prescaler; o_sample marks the last clk of each column slot.
module kb_scan_tick #(
  parameter int SCAN_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  output logic o_sample
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_sample = (r_cnt == CNT_LAST);

endmodule

// File: rtl/keypad_digit_buffer.sv
// Keypad scanner with press/release debounce feeding a shift buffer of hex digits.
// NUM_DIGITS is expected in 2..7 (digit count output is 3 bits).
//
//   state         | meaning
//   ST_SCAN       | walking columns, waiting for exactly one low row
//   ST_PRESS_DB   | column held, counting identical row samples
//   ST_ACCEPT     | key_valid high for one clk; buffer pushed at end of this clk
//   ST_RELEASE_DB | counting idle row samples before scanning resumes
module keypad_digit_buffer
  import keypad_digit_buffer_pkg::*;
#(
  parameter int SCAN_DIV       = 16,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int NUM_DIGITS     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    i_kb_row,
  input  logic                          i_clr,
  output logic [3:0]                    o_kb_col,
  output logic [DIGIT_W*NUM_DIGITS-1:0] o_digit_buf,
  output logic [2:0]                    o_digit_cnt,
  output logic                          o_key_valid,
  output logic [3:0]                    o_key_code,
  output logic                          o_overflow
);

  localparam int BUF_W = DIGIT_W * NUM_DIGITS;
  localparam int MW    = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [MW-1:0] MATCH_LAST = MW'(DEBOUNCE_SCANS - 1);
  localparam logic [2:0]    CNT_FULL   = 3'(NUM_DIGITS);

  logic             w_sample;
  logic [3:0]       w_code;
  logic             w_full;
  logic [3:0]       r_row_meta;
  logic [3:0]       r_row_sync;
  kb_state_e        r_state;
  logic [3:0]       r_col;
  logic [3:0]       r_row_lat;
  logic [MW-1:0]    r_match;
  logic             r_key_valid;
  logic [3:0]       r_key_code;
  logic             r_ovf_pend;
  logic [BUF_W-1:0] r_buf;
  logic [2:0]       r_cnt;

  kb_scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .o_sample (w_sample)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_meta <= KB_IDLE;
      r_row_sync <= KB_IDLE;
    end else begin
      r_row_meta <= i_kb_row;
      r_row_sync <= r_row_meta;
    end
  end

  assign w_code = {low_index(r_row_sync), low_index(r_col)};
  assign w_full = (r_cnt == CNT_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_SCAN;
      r_col       <= COL_RESET;
      r_row_lat   <= KB_IDLE;
      r_match     <= '0;
      r_key_valid <= 1'b0;
      r_key_code  <= 4'h0;
      r_ovf_pend  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      r_ovf_pend  <= 1'b0;
      case (r_state)
        ST_SCAN: begin
          if (w_sample) begin
            if (one_low(r_row_sync)) begin
              r_row_lat <= r_row_sync;
              r_match   <= MW'(1);
              if (DEBOUNCE_SCANS == 1) begin
                r_state     <= ST_ACCEPT;
                r_key_valid <= 1'b1;
                r_key_code  <= w_code;
                r_ovf_pend  <= w_full && !i_clr;
              end else begin
                r_state <= ST_PRESS_DB;
              end
            end else begin
              r_col <= {r_col[2:0], r_col[3]};
            end
          end
        end
        ST_PRESS_DB: begin
          if (w_sample) begin
            if (r_row_sync == r_row_lat) begin
              if (r_match == MATCH_LAST) begin
                r_state     <= ST_ACCEPT;
                r_key_valid <= 1'b1;
                r_key_code  <= w_code;
                r_ovf_pend  <= w_full && !i_clr;
              end else begin
                r_match <= r_match + MW'(1);
              end
            end else begin
              r_state <= ST_SCAN;
            end
          end
        end
        ST_ACCEPT: begin
          r_state <= ST_RELEASE_DB;
          r_match <= '0;
        end
        ST_RELEASE_DB: begin
          if (w_sample) begin
            if (r_row_sync == KB_IDLE) begin
              if (r_match == MATCH_LAST) begin
                r_state <= ST_SCAN;
                r_col   <= {r_col[2:0], r_col[3]};
              end else begin
                r_match <= r_match + MW'(1);
              end
            end else begin
              r_match <= '0;
            end
          end
        end
        default: r_state <= ST_SCAN;
      endcase
    end
  end

  // The push happens as ACCEPT ends, so a clr during ACCEPT discards the key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf <= '0;
      r_cnt <= 3'd0;
    end else if (i_clr) begin
      r_buf <= '0;
      r_cnt <= 3'd0;
    end else if (r_state == ST_ACCEPT) begin
      r_buf <= {r_buf[BUF_W-DIGIT_W-1:0], r_key_code};
      if (!w_full) r_cnt <= r_cnt + 3'd1;
    end
  end

  assign o_kb_col    = r_col;
  assign o_digit_buf = r_buf;
  assign o_digit_cnt = r_cnt;
  assign o_key_valid = r_key_valid;
  assign o_key_code  = r_key_code;
  assign o_overflow  = r_ovf_pend & ~i_clr;

endmodule
